// File: rtl/ddr_port_arbiter_if.sv
// Client and DDR-controller handshake signals of the four-client DDR port arbiter.
// The slave modport is the arbiter's view; master is the clients and the DDR controller.
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_ack;
    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_ack;
    logic [DATA_W-1:0] rd_data;
    logic              wr0_req;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ack;
    logic              wr1_req;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ack;
    logic              ddr_read;
    logic [ADDR_W-1:0] ddr_read_addr;
    logic              ddr_read_ack;
    logic [DATA_W-1:0] ddr_read_data;
    logic              ddr_write;
    logic [ADDR_W-1:0] ddr_write_addr;
    logic [DATA_W-1:0] ddr_write_data;
    logic              ddr_write_ack;
    logic              busy;

    modport slave (
        input  rd0_req, rd0_addr, rd1_req, rd1_addr,
        input  wr0_req, wr0_addr, wr0_data, wr1_req, wr1_addr, wr1_data,
        input  ddr_read_ack, ddr_read_data, ddr_write_ack,
        output rd0_ack, rd1_ack, rd_data, wr0_ack, wr1_ack,
        output ddr_read, ddr_read_addr, ddr_write, ddr_write_addr, ddr_write_data, busy
    );

    modport master (
        output rd0_req, rd0_addr, rd1_req, rd1_addr,
        output wr0_req, wr0_addr, wr0_data, wr1_req, wr1_addr, wr1_data,
        output ddr_read_ack, ddr_read_data, ddr_write_ack,
        input  rd0_ack, rd1_ack, rd_data, wr0_ack, wr1_ack,
        input  ddr_read, ddr_read_addr, ddr_write, ddr_write_addr, ddr_write_data, busy
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Serialises four clients (display read, graphics read/write, host write) onto one DDR
// controller port; display reads have starvation-bounded priority, the rest are round-robin.
module ddr_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    ddr_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    // Client index: bit 1 set means a write client, so grant[1] selects the DDR direction.
    localparam logic [1:0] C_RD0 = 2'd0;
    localparam logic [1:0] C_RD1 = 2'd1;
    localparam logic [1:0] C_WR1 = 2'd3;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t                  state;
    logic [1:0]              grant, rr_ptr, rr_win, win, c1, c2;
    logic [7:0]              starve_cnt;
    logic [3:0]              req, ack;
    logic [3:0][ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]       win_wdata;
    logic                    others, starve_hit, win_any, ddr_ack_any, cur_ack;
    logic                    ddr_read, ddr_write, busy;
    logic [ADDR_W-1:0]       ddr_read_addr, ddr_write_addr;
    logic [DATA_W-1:0]       ddr_write_data, rd_data;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == C_WR1) ? C_RD1 : p + 2'd1;
    endfunction

    assign req  = {bus.wr1_req, bus.wr0_req, bus.rd1_req, bus.rd0_req};
    assign addr = {bus.wr1_addr, bus.wr0_addr, bus.rd1_addr, bus.rd0_addr};

    assign c1         = rr_next(rr_ptr);
    assign c2         = rr_next(c1);
    assign others     = |req[3:1];
    assign starve_hit = (starve_cnt == LIMIT) && others;
    assign win_any    = |req;
    assign ddr_ack_any = bus.ddr_read_ack | bus.ddr_write_ack;
    assign cur_ack    = grant[1] ? bus.ddr_write_ack : bus.ddr_read_ack;
    assign win_wdata  = win[0] ? bus.wr1_data : bus.wr0_data;

    always_comb begin
        rr_win = c2;
        if (req[rr_ptr])  rr_win = rr_ptr;
        else if (req[c1]) rr_win = c1;
        win = (req[C_RD0] && !starve_hit) ? C_RD0 : rr_win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= C_RD0;
            rr_ptr         <= C_RD1;
            starve_cnt     <= '0;
            ack            <= '0;
            busy           <= 1'b0;
            ddr_read       <= 1'b0;
            ddr_write      <= 1'b0;
            ddr_read_addr  <= '0;
            ddr_write_addr <= '0;
            ddr_write_data <= '0;
            rd_data        <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    // A lingering ack from the previous transaction blocks the next grant.
                    if (!ddr_ack_any && win_any) begin
                        grant <= win;
                        state <= WAIT;
                        busy  <= 1'b1;
                        if (win[1]) begin
                            ddr_write      <= 1'b1;
                            ddr_write_addr <= addr[win];
                            ddr_write_data <= win_wdata;
                        end else begin
                            ddr_read      <= 1'b1;
                            ddr_read_addr <= addr[win];
                        end
                        if (win == C_RD0) begin
                            if (others && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 8'd1;
                        end else begin
                            starve_cnt <= '0;
                            rr_ptr     <= rr_next(win);
                        end
                    end
                end
                WAIT: begin
                    if (cur_ack) begin
                        if (!grant[1]) rd_data <= bus.ddr_read_data;
                        ack[grant] <= 1'b1;
                        ddr_read   <= 1'b0;
                        ddr_write  <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!cur_ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd0_ack        = ack[0];
    assign bus.rd1_ack        = ack[1];
    assign bus.wr0_ack        = ack[2];
    assign bus.wr1_ack        = ack[3];
    assign bus.rd_data        = rd_data;
    assign bus.ddr_read       = ddr_read;
    assign bus.ddr_read_addr  = ddr_read_addr;
    assign bus.ddr_write      = ddr_write;
    assign bus.ddr_write_addr = ddr_write_addr;
    assign bus.ddr_write_data = ddr_write_data;
    assign bus.busy           = busy;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: a small DDR controller model answers the port,
// completions are collected by a monitor and matched against expected transactions.
`timescale 1ns/1ps
module tb_ddr_port_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    ddr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int            client;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // DDR model knobs and state
    int            lat = 2, hold_extra = 0, lat_cnt = 0, hold_left = 0;
    logic [DW-1:0] rkey = '0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    bit            dropped = 0;

    // monitor flags
    bit   overlap = 0, read_seen = 0, hold_viol = 0, multi_ack = 0, long_ack = 0, rq_prev = 0;
    int   grant_cnt = 0;
    logic [3:0] prev_acks = '0;

    // DDR controller model: level request, ack after lat cycles, ack held until request drops
    // plus hold_extra cycles.
    initial begin
        bus.ddr_read_ack  = 1'b0;
        bus.ddr_write_ack = 1'b0;
        bus.ddr_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.ddr_read_ack || bus.ddr_write_ack) begin
                if (!(bus.ddr_read_ack ? bus.ddr_read : bus.ddr_write)) begin
                    if (hold_left == 0) begin
                        bus.ddr_read_ack  = 1'b0;
                        bus.ddr_write_ack = 1'b0;
                        dropped = 0;
                    end else begin
                        hold_left--;
                        dropped = 1;
                    end
                end
            end else if (bus.ddr_read || bus.ddr_write) begin
                if (lat_cnt >= lat) begin
                    lat_cnt   = 0;
                    hold_left = hold_extra;
                    if (bus.ddr_read) begin
                        cap_addr          = bus.ddr_read_addr;
                        bus.ddr_read_data = bus.ddr_read_addr[15:0] ^ rkey;
                        bus.ddr_read_ack  = 1'b1;
                    end else begin
                        cap_addr          = bus.ddr_write_addr;
                        cap_wdata         = bus.ddr_write_data;
                        bus.ddr_write_ack = 1'b1;
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // completion monitor
    initial begin
        logic [3:0] acks;
        logic       rq;
        txn_t       o;
        forever begin
            @(negedge clk);
            if (bus.ddr_read && bus.ddr_write) overlap = 1;
            if (bus.ddr_read) read_seen = 1;
            if (dropped && (bus.ddr_read || bus.ddr_write)) hold_viol = 1;
            rq = bus.ddr_read | bus.ddr_write;
            if (rq && !rq_prev) grant_cnt++;
            rq_prev = rq;
            acks = {bus.wr1_ack, bus.wr0_ack, bus.rd1_ack, bus.rd0_ack};
            if ($countones(acks) > 1) multi_ack = 1;
            if ((acks & prev_acks) != 4'b0) long_ack = 1;
            prev_acks = acks;
            if (acks != 4'b0) begin
                o.client = 0;
                for (int i = 3; i >= 0; i--) if (acks[i]) o.client = i;
                o.addr = cap_addr;
                o.data = (o.client < 2) ? bus.rd_data : cap_wdata;
                obs_q.push_back(o);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic wait_obs(input int max_cyc, output bit ok);
        for (int i = 0; i < max_cyc && obs_q.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic push_exp(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t e;
        e.client = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        bit quiet = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.ddr_read, bus.ddr_write, bus.busy, bus.rd0_ack, bus.rd1_ack, bus.wr0_ack, bus.wr1_ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rd=%b wr=%b busy=%b want all 0", bus.ddr_read, bus.ddr_write, bus.busy);
        end
        n_tests++;
        if (bus.ddr_read_addr !== '0 || bus.ddr_write_addr !== '0 || bus.ddr_write_data !== '0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got ra=%h wa=%h wd=%h rd=%h want 0", bus.ddr_read_addr, bus.ddr_write_addr, bus.ddr_write_data, bus.rd_data);
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ddr_read || bus.ddr_write || bus.busy) quiet = 0;
        end
        n_tests++;
        if (!quiet || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got quiet=%0d acks=%0d want quiet=1 acks=0", quiet, obs_q.size());
        end
    endtask

    task automatic test_single_read();
        bit ok; txn_t o, e;
        exp_q.delete(); obs_q.delete();
        rkey = 16'h3456 ^ 16'hBEEF; lat = 3;
        @(negedge clk);
        bus.rd1_addr = 24'h123456; bus.rd1_req = 1'b1;
        push_exp(1, 24'h123456, 16'hBEEF);
        wait_obs(50, ok);
        bus.rd1_req = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rd1_timeout: got no ack want rd1_ack");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.client !== e.client || o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL rd1_txn: got c%0d %h %h want c%0d %h %h", o.client, o.addr, o.data, e.client, e.addr, e.data);
            end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rd1_extra: got acks=%0d busy=%b want 0 0", obs_q.size(), bus.busy);
        end
        n_tests++;
        if (bus.rd_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_data_hold: got %h want beef", bus.rd_data);
        end
    endtask

    task automatic test_single_write();
        bit ok; txn_t o, e;
        exp_q.delete(); obs_q.delete();
        read_seen = 0; lat = 2;
        @(negedge clk);
        bus.wr0_addr = 24'h000010; bus.wr0_data = 16'hA5A5; bus.wr0_req = 1'b1;
        push_exp(2, 24'h000010, 16'hA5A5);
        wait_obs(50, ok);
        bus.wr0_req = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL wr0_timeout: got no ack want wr0_ack");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.client !== e.client || o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL wr0_txn: got c%0d %h %h want c%0d %h %h", o.client, o.addr, o.data, e.client, e.addr, e.data);
            end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (read_seen || obs_q.size() != 0) begin
            n_fail++; $display("FAIL wr0_side: got read_seen=%0d acks=%0d want 0 0", read_seen, obs_q.size());
        end
    endtask

    task automatic test_starvation();
        bit ok; txn_t o, e;
        logic [AW-1:0] ra [4];
        logic [DW-1:0] rd [4];
        exp_q.delete(); obs_q.delete();
        ra[0] = 24'h000100; ra[1] = 24'h000200; ra[2] = 24'h000300; ra[3] = 24'h000400;
        rd[0] = 16'h0100;   rd[1] = 16'h0200;   rd[2] = 16'h1111;   rd[3] = 16'h2222;
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        rkey = '0; lat = 1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 8; k++) push_exp(0, ra[0], rd[0]);
            push_exp(g + 1, ra[g + 1], rd[g + 1]);
        end
        bus.rd0_addr = ra[0]; bus.rd1_addr = ra[1];
        bus.wr0_addr = ra[2]; bus.wr0_data = rd[2];
        bus.wr1_addr = ra[3]; bus.wr1_data = rd[3];
        bus.rd0_req = 1'b1; bus.rd1_req = 1'b1; bus.wr0_req = 1'b1; bus.wr1_req = 1'b1;
        for (int i = 0; i < 27; i++) begin
            wait_obs(60, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL starve_timeout: got no ack at grant %0d want ack", i);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.client !== e.client || o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got c%0d %h %h want c%0d %h %h", i, o.client, o.addr, o.data, e.client, e.addr, e.data);
            end
        end
        bus.rd0_req = 1'b0; bus.rd1_req = 1'b0; bus.wr0_req = 1'b0; bus.wr1_req = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL starve_drain: got %0d extra acks want 0", obs_q.size());
        end
    endtask

    // two clients held; each req drops in its own ack cycle
    task automatic run_pair(input string nm, input int max_cyc);
        bit ok; txn_t o, e;
        for (int i = 0; i < 2; i++) begin
            wait_obs(max_cyc, ok);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL %s_timeout: got no ack at txn %0d want ack", nm, i);
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.client == 1) bus.rd1_req = 1'b0;
            if (o.client == 3) bus.wr1_req = 1'b0;
            if (o.client !== e.client || o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL %s_txn%0d: got c%0d %h %h want c%0d %h %h", nm, i, o.client, o.addr, o.data, e.client, e.addr, e.data);
            end
        end
        bus.rd1_req = 1'b0; bus.wr1_req = 1'b0;
    endtask

    task automatic test_ack_hold();
        exp_q.delete(); obs_q.delete();
        hold_extra = 5; lat = 2; rkey = '0; hold_viol = 0;
        @(negedge clk);
        bus.rd1_addr = 24'h000AAA;
        bus.wr1_addr = 24'h000BBB; bus.wr1_data = 16'h7777;
        push_exp(1, 24'h000AAA, 16'h0AAA);
        push_exp(3, 24'h000BBB, 16'h7777);
        bus.rd1_req = 1'b1; bus.wr1_req = 1'b1;
        run_pair("ack_hold", 80);
        repeat (12) @(negedge clk);
        hold_extra = 0;
        n_tests++;
        if (hold_viol || overlap) begin
            n_fail++; $display("FAIL ack_hold_gap: got hold_viol=%0d overlap=%0d want 0 0", hold_viol, overlap);
        end
    endtask

    task automatic test_drop_during_wait();
        bit ok; txn_t o, e;
        int g0;
        exp_q.delete(); obs_q.delete();
        lat = 6; rkey = '0;
        @(negedge clk);
        g0 = grant_cnt;
        bus.rd1_addr = 24'h00C0DE; bus.rd1_req = 1'b1;
        push_exp(1, 24'h00C0DE, 16'hC0DE);
        for (int i = 0; i < 10 && !bus.busy; i++) @(negedge clk);
        @(negedge clk);
        bus.rd1_req = 1'b0;
        wait_obs(50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL drop_timeout: got no ack want rd1_ack");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.client !== e.client || o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL drop_txn: got c%0d %h %h want c%0d %h %h", o.client, o.addr, o.data, e.client, e.addr, e.data);
            end
        end
        repeat (15) @(negedge clk);
        n_tests++;
        if (grant_cnt - g0 != 1 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL drop_regrant: got grants=%0d acks=%0d want 1 0", grant_cnt - g0, obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); obs_q.delete();
        lat = 10;
        @(negedge clk);
        bus.wr0_addr = 24'h000777; bus.wr0_data = 16'h1234; bus.wr0_req = 1'b1;
        for (int i = 0; i < 10 && !bus.ddr_write; i++) @(negedge clk);
        n_tests++;
        if (bus.ddr_write !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_start: got ddr_write=%b want 1", bus.ddr_write);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.ddr_write, bus.ddr_read, bus.busy, bus.rd0_ack, bus.rd1_ack, bus.wr0_ack, bus.wr1_ack} !== 7'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got wr=%b rd=%b busy=%b want 0", bus.ddr_write, bus.ddr_read, bus.busy);
        end
        bus.wr0_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lat = 2;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL rstmid_noack: got %0d acks want 0", obs_q.size());
        end
        bus.rd1_addr = 24'h000321;
        bus.wr1_addr = 24'h000654; bus.wr1_data = 16'h4321;
        push_exp(1, 24'h000321, 16'h0321);
        push_exp(3, 24'h000654, 16'h4321);
        bus.rd1_req = 1'b1; bus.wr1_req = 1'b1;
        run_pair("rstmid", 60);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_invariants();
        n_tests++;
        if (overlap || multi_ack || long_ack) begin
            n_fail++; $display("FAIL invariants: got overlap=%0d multi_ack=%0d long_ack=%0d want 0 0 0", overlap, multi_ack, long_ack);
        end
    endtask

    initial begin
        bus.rd0_req = 1'b0; bus.rd0_addr = '0;
        bus.rd1_req = 1'b0; bus.rd1_addr = '0;
        bus.wr0_req = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_req = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_starvation();
        test_ack_hold();
        test_drop_during_wait();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
